// File: rtl/mem_access_unit_if.sv
// Request/response handshake and Memory-port bundle of mem_access_unit.
// slave  : the access unit (accepts requests, drives the Memory port).
// master : the environment (issues requests, returns Memory read data).
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_din, mem_read, mem_write
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_din, mem_read, mem_write
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the memory stage and the
// word-wide data Memory. One request per handshake, one-cycle response strobe.
// Optional feature macro MAU_SUBWORD_EN: enables B/H/BU/HU loads and B/H
// stores (read-modify-write). Without it only word accesses are legal and
// the RMW_READ state and merge path do not exist.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request; no memory strobe, mem_addr = 0
// READ     | load: word read, addressed lane extracted into response reg
// RMW_READ | B/H store: word read and merged with the store data
// WRITE    | word (or merged word) written to memory
// RESP     | one-cycle response strobe, then back to IDLE
module mem_access_unit #(
   parameter int MEM_DEPTH = 16384
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);

   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
   localparam logic [2:0]  F3_W    = 3'b010;
`ifdef MAU_SUBWORD_EN
   localparam logic [2:0]  F3_B    = 3'b000;
   localparam logic [2:0]  F3_H    = 3'b001;
   localparam logic [2:0]  F3_BU   = 3'b100;
   localparam logic [2:0]  F3_HU   = 3'b101;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_READ     = 3'd1,
`ifdef MAU_SUBWORD_EN
      S_RMW_READ = 3'd2,
`endif
      S_WRITE    = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        accept;
   logic        dec_err;
   logic [29:0] word_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] load_data;

`ifdef MAU_SUBWORD_EN
   logic [1:0]  lane_q;
   logic [2:0]  funct3_q;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] merged;
`endif

   assign accept = bus.req_valid & (state_q == S_IDLE);

   // Request legality: funct3/alignment per access size, and word range.
   always_comb begin
      dec_err = 1'b0;
`ifdef MAU_SUBWORD_EN
      case (bus.req_funct3)
         F3_B:    dec_err = 1'b0;
         F3_H:    dec_err = bus.req_addr[0];
         F3_W:    dec_err = |bus.req_addr[1:0];
         F3_BU:   dec_err = bus.req_write;
         F3_HU:   dec_err = bus.req_write | bus.req_addr[0];
         default: dec_err = 1'b1;
      endcase
`else
      dec_err = (bus.req_funct3 != F3_W) | (|bus.req_addr[1:0]);
`endif
      // No wrap-around: anything past the last word is rejected outright.
      if ({2'b00, bus.req_addr[31:2]} >= DEPTH_W) begin
         dec_err = 1'b1;
      end
   end

`ifdef MAU_SUBWORD_EN
   // Lane extraction and zero/sign extension of load data (little-endian).
   always_comb begin
      case (lane_q)
         2'd0:    lane_b = bus.mem_dout[7:0];
         2'd1:    lane_b = bus.mem_dout[15:8];
         2'd2:    lane_b = bus.mem_dout[23:16];
         default: lane_b = bus.mem_dout[31:24];
      endcase
      lane_h = lane_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
      case (funct3_q)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_BU:   load_data = {24'h0, lane_b};
         F3_HU:   load_data = {16'h0, lane_h};
         default: load_data = bus.mem_dout;
      endcase
   end

   // Store merge: replace the target byte/halfword of the word just read.
   always_comb begin
      merged = bus.mem_dout;
      if (funct3_q[0]) begin
         if (lane_q[1]) merged[31:16] = wdata_q[15:0];
         else           merged[15:0]  = wdata_q[15:0];
      end else begin
         case (lane_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end
`else
   // Word-only build: loads return the memory word unchanged.
   always_comb begin
      load_data = bus.mem_dout;
   end
`endif

   // State register; reset forces IDLE immediately, aborting any access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (dec_err)                state_d = S_RESP;
               else if (!bus.req_write)    state_d = S_READ;
`ifdef MAU_SUBWORD_EN
               else if (bus.req_funct3 != F3_W) state_d = S_RMW_READ;
`endif
               else                        state_d = S_WRITE;
            end
         end
         S_READ:     state_d = S_RESP;
`ifdef MAU_SUBWORD_EN
         S_RMW_READ: state_d = S_WRITE;
`endif
         S_WRITE:    state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Moore outputs: strobes and response fields are pure functions of state.
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.resp_err   = 1'b0;
      bus.mem_addr   = {word_q, 2'b00};
      bus.mem_din    = 32'h0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            bus.mem_addr  = 32'h0;
         end
         S_READ:     bus.mem_read = 1'b1;
`ifdef MAU_SUBWORD_EN
         S_RMW_READ: bus.mem_read = 1'b1;
`endif
         S_WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_din   = wdata_q;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = rdata_q;
            bus.resp_err   = err_q;
         end
         default: bus.mem_addr = 32'h0;
      endcase
   end

   // Request latch, load result capture and merged-word capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
`ifdef MAU_SUBWORD_EN
         lane_q   <= '0;
         funct3_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  word_q   <= bus.req_addr[31:2];
                  wdata_q  <= bus.req_wdata;
                  rdata_q  <= '0;
                  err_q    <= dec_err;
`ifdef MAU_SUBWORD_EN
                  lane_q   <= bus.req_addr[1:0];
                  funct3_q <= bus.req_funct3;
`endif
               end
            end
            S_READ:     rdata_q <= load_data;
`ifdef MAU_SUBWORD_EN
            S_RMW_READ: wdata_q <= merged;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases with literal
// expectations plus a randomized phase checked every cycle against a
// byte-level reference model and a reference memory image.
module tb_mem_access_unit;

   localparam int MEM_DEPTH = 16384;
`ifdef MAU_SUBWORD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Attached data Memory: combinational read, write on rising edge.
   logic [31:0] mem     [MEM_DEPTH];
   logic [31:0] ref_mem [MEM_DEPTH];

   assign bus.mem_dout = (bus.mem_addr[31:16] == 16'h0) ? mem[bus.mem_addr[15:2]] : 32'h0;

   always @(posedge clk) begin
      if (bus.mem_write && bus.mem_addr[31:16] == 16'h0) mem[bus.mem_addr[15:2]] <= bus.mem_din;
   end

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic void timeout_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out, expected a response", nm);
   endfunction

   // ---------------- reference model ----------------
   bit          busy = 1'b0;
   int          cd;
   bit          m_err, m_store;
   int          m_size;
   logic [31:0] m_addr, m_rdata, m_din;
   bit          rdy, ev, erd, ewr;
   logic [31:0] ea;

   function automatic void model_accept();
      logic [31:0] a, w, wd, raw, mask;
      logic [2:0]  f3;
      int          off;
      bit          legal;
      a  = bus.req_addr;
      f3 = bus.req_funct3;
      wd = bus.req_wdata;
      m_store = bus.req_write;
      m_addr  = a;
      m_size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (!SUB)         legal = (f3 == 3'b010);
      else if (m_store) legal = (f3 <= 3'b010);
      else              legal = (f3 != 3'b011) && (f3 <= 3'b101);
      m_err   = !legal || ((a & 32'(m_size - 1)) != 32'h0) || ((a >> 2) >= 32'(MEM_DEPTH));
      m_rdata = 32'h0;
      m_din   = 32'h0;
      if (!m_err) begin
         w   = ref_mem[a[15:2]];
         off = int'(a[1:0]);
         if (!m_store) begin
            raw = w >> (8 * off);
            if (m_size == 1) begin
               raw = raw & 32'hFF;
               if (!f3[2] && raw[7]) raw = raw | 32'hFFFFFF00;
            end else if (m_size == 2) begin
               raw = raw & 32'hFFFF;
               if (!f3[2] && raw[15]) raw = raw | 32'hFFFF0000;
            end
            m_rdata = raw;
         end else if (m_size == 4) begin
            m_din = wd;
         end else begin
            mask  = ((m_size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
            m_din = (w & ~mask) | ((wd << (8 * off)) & mask);
         end
      end
      cd   = m_err ? 1 : (!m_store ? 2 : (m_size == 4 ? 2 : 3));
      busy = 1'b1;
   endfunction

   // Per-cycle compare against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         busy = 1'b0;
         check("rst_req_ready",  32'(bus.req_ready),  32'h1);
         check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
         check("rst_resp_rdata", bus.resp_rdata,      32'h0);
         check("rst_resp_err",   32'(bus.resp_err),   32'h0);
         check("rst_mem_addr",   bus.mem_addr,        32'h0);
         check("rst_mem_din",    bus.mem_din,         32'h0);
         check("rst_mem_read",   32'(bus.mem_read),   32'h0);
         check("rst_mem_write",  32'(bus.mem_write),  32'h0);
      end else begin
         rdy = !busy;
         if (busy) cd--;
         ev  = busy && (cd == 0);
         erd = busy && !m_err && ((!m_store && cd == 1) || (m_store && m_size != 4 && cd == 2));
         ewr = busy && !m_err && m_store && (cd == 1);
         ea  = busy ? {m_addr[31:2], 2'b00} : 32'h0;
         check("req_ready",  32'(bus.req_ready),  32'(rdy));
         check("resp_valid", 32'(bus.resp_valid), 32'(ev));
         check("mem_read",   32'(bus.mem_read),   32'(erd));
         check("mem_write",  32'(bus.mem_write),  32'(ewr));
         check("mem_addr",   bus.mem_addr,        ea);
         if (ewr) check("mem_din", bus.mem_din, m_din);
         if (ev) begin
            check("resp_rdata", bus.resp_rdata,      m_rdata);
            check("resp_err",   32'(bus.resp_err),   32'(m_err));
            if (m_store && !m_err) ref_mem[m_addr[15:2]] = m_din;
            busy = 1'b0;
         end
         if (bus.req_valid && rdy) model_accept();
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int lat);
      int waitc;
      rd  = 32'h0;
      er  = 1'b0;
      lat = -1;
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      waitc = 0;
      @(negedge clk);
      while (!bus.req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!bus.req_ready) begin
         timeout_fail("req_ready_wait");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            lat = i;
            break;
         end
      end
      if (lat < 0) timeout_fail("resp_wait");
   endtask

   task automatic expect_txn(input string nm, input bit w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] erd, input bit eerr, input int elat);
      logic [31:0] rd;
      bit          er;
      int          lat;
      txn(w, f3, a, wd, rd, er, lat);
      if (lat >= 0) begin
         check({nm, "_rdata"}, rd,       erd);
         check({nm, "_err"},   32'(er),  32'(eerr));
         check({nm, "_lat"},   32'(lat), 32'(elat));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         mem[i]     <= 32'h0;
         ref_mem[i]  = 32'h0;
      end
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("init_ready",    32'(bus.req_ready),  32'h1);
      check("init_resp_vld", 32'(bus.resp_valid), 32'h0);
      check("init_mem_addr", bus.mem_addr,        32'h0);
      @(posedge clk); #1 reset = 1'b1;

      // Word store/load round trip.
      expect_txn("sw_8",  1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0,        0, 2);
      expect_txn("lw_8",  0, 3'b010, 32'h8, 32'h0,        32'hDEADBEEF, 0, 2);

      // Sub-word loads from 0x11223380.
      expect_txn("sw_pat", 1, 3'b010, 32'h8, 32'h11223380, 32'h0, 0, 2);
      expect_txn("lb_b",  0, 3'b000, 32'hB, 0, SUB ? 32'h00000011 : 32'h0, !SUB, SUB ? 2 : 1);
      expect_txn("lb_8",  0, 3'b000, 32'h8, 0, SUB ? 32'hFFFFFF80 : 32'h0, !SUB, SUB ? 2 : 1);
      expect_txn("lbu_8", 0, 3'b100, 32'h8, 0, SUB ? 32'h00000080 : 32'h0, !SUB, SUB ? 2 : 1);
      expect_txn("lhu_a", 0, 3'b101, 32'hA, 0, SUB ? 32'h00001122 : 32'h0, !SUB, SUB ? 2 : 1);
      expect_txn("lh_8",  0, 3'b001, 32'h8, 0, SUB ? 32'h00003380 : 32'h0, !SUB, SUB ? 2 : 1);
      expect_txn("lb_0",  0, 3'b000, 32'h0, 0, 32'h0, !SUB, SUB ? 2 : 1);

      // Byte store read-modify-write.
      expect_txn("sw_rmw", 1, 3'b010, 32'h8, 32'h11223344, 32'h0, 0, 2);
      expect_txn("sb_9",   1, 3'b000, 32'h9, 32'h000000AB, 32'h0, !SUB, SUB ? 3 : 1);
      @(negedge clk);
      check("sb_9_mem", mem[2], SUB ? 32'h1122AB44 : 32'h11223344);

      // Error cases: one-cycle response, no strobes (strobes checked per cycle).
      expect_txn("lw_mis",  0, 3'b010, 32'h6,     0, 32'h0, 1, 1);
      expect_txn("sh_mis",  1, 3'b001, 32'h3,     0, 32'h0, 1, 1);
      expect_txn("f3_011",  0, 3'b011, 32'h0,     0, 32'h0, 1, 1);
      expect_txn("lw_oor",  0, 3'b010, 32'h10000, 0, 32'h0, 1, 1);

      // Highest legal word.
      expect_txn("sw_top", 1, 3'b010, 32'hFFFC, 32'hA5A55A5A, 32'h0,        0, 2);
      expect_txn("lw_top", 0, 3'b010, 32'hFFFC, 32'h0,        32'hA5A55A5A, 0, 2);

      // Reset during WRITE of a word store to 0x10.
      expect_txn("sw_10", 1, 3'b010, 32'h10, 32'h12345678, 32'h0, 0, 2);
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'hCAFEF00D;
      @(negedge clk);
      check("rst_pre_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("rst_wr_active", 32'(bus.mem_write), 32'h1);
      reset = 1'b0;
      #1;
      check("rst_wr_drop", 32'(bus.mem_write), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_post_ready", 32'(bus.req_ready),  32'h1);
      check("rst_post_resp",  32'(bus.resp_valid), 32'h0);
      check("rst_mem4",       mem[4],              32'h12345678);

      // Randomized phase: free-running requests, valid also held while busy.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         r = $urandom_range(0, 19);
         if (r < 16)       a = {26'h0, 4'(r), 2'($urandom_range(0, 3))};
         else if (r == 16) a = 32'((MEM_DEPTH - 1) * 4) | 32'($urandom_range(0, 3));
         else if (r == 17) a = 32'(MEM_DEPTH * 4) | 32'($urandom_range(0, 3));
         else              a = $urandom;
         bus.req_valid  = ($urandom_range(0, 9) < 6);
         bus.req_write  = 1'($urandom_range(0, 1));
         bus.req_funct3 = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
         bus.req_addr   = a;
         bus.req_wdata  = $urandom;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);
      check("mem_final_top", mem[MEM_DEPTH - 1], ref_mem[MEM_DEPTH - 1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Load/store initiator between the datapath's memory stage and the data `Memory` block.
- Accepts one load or store per valid/ready handshake, RISC-V `funct3` sized and signed.
- Drives word-aligned `addr`/`din`/`mem_read`/`mem_write` into `Memory`.
- Performs read-modify-write for byte/halfword stores and returns extracted or sign-extended load data on a one-cycle response strobe.

## Interface
- `MEM_DEPTH`, 16384: words in the attached `Memory`. Word index `addr>>2 >= MEM_DEPTH` is out of range.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low bytes used for B/H.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal funct3 or out-of-range; valid with `resp_valid`.
- `mem_addr`  out  32  to `Memory.addr`; always word-aligned (low 2 bits 0).
- `mem_din`  out  32  to `Memory.din`.
- `mem_read`  out  1  to `Memory.mem_read`.
- `mem_write`  out  1  to `Memory.mem_write`.
- `mem_dout`  in  32  from `Memory.dout`; combinational, valid in the same cycle `mem_read`=1.

## Operation
- FSM states: IDLE, READ, RMW_READ, WRITE, RESP. The request is latched on `req_valid & req_ready`.
- IDLE transitions:
  - Error (H/HU with addr[0]=1; W with addr[1:0]≠0; funct3 011/110/111; store with funct3≥011; out of range) → RESP with err.
  - Load → READ.
  - Store W → WRITE.
  - Store B/H → RMW_READ.
- READ: `mem_read`=1. The addressed lane is captured at the edge and zero- or sign-extended per funct3. Lane = addr[1:0] for B, addr[1] for H (little-endian). Next state RESP.
- RMW_READ: `mem_read`=1. The captured word has the target byte/halfword replaced by `req_wdata[7:0]`/`[15:0]`, other bytes kept. Next state WRITE.
- WRITE: `mem_write`=1, `mem_din` = merged word (or `req_wdata` for W). Next state RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Errors issue no memory strobe.
- `mem_read` and `mem_write` are never both 1. Strobes are Moore outputs of the state.
- `mem_addr` = {latched addr[31:2], 2'b00} in every state except IDLE, where it is 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_addr`=0, `mem_din`=0, `mem_read`=0, `mem_write`=0.
- Latency from the accept edge to the cycle with `resp_valid` high:
  - Error: 1 cycle.
  - Load and W store: 2 cycles.
  - B/H store: 3 cycles.
- `req_ready` is 0 from the accept edge until back in IDLE. Back-to-back throughput is one request per (latency+1) cycles.
- `req_valid` held while `req_ready`=0 is ignored, not queued.
- Reset asserted mid-operation: immediate return to IDLE. `mem_write` drops asynchronously, so no partial write occurs. The in-flight request gets no response.
- Highest legal word (`MEM_DEPTH-1`) is accessed normally. Address wrap-around is never performed.

## Configuration
- `MAU_SUBWORD_EN` defined: B/H/BU/HU loads and B/H stores supported as above.
- Not defined:
  - Only funct3=010 is legal. All other funct3 values take the error path.
  - RMW_READ state and merge logic are removed.
  - W behaviour and latency are unchanged.

## Test plan
- Reset low mid-WRITE of a store W to 0x10: `mem_write` falls at once, `mem[4]` unchanged, no `resp_valid`, `req_ready`=1 after release.
- Store W 0xDEADBEEF @0x8, then load W @0x8 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, response 2 cycles after each accept.
- With `mem[2]`=0x11223380: load B @0xB → 0x00000011; load B @0x8 → 0xFFFFFF80; load BU @0x8 → 0x00000080; load HU @0xA → 0x00001122.
- Store B 0xAB @0x9 over 0x11223344: RMW_READ then WRITE, `mem[2]`=0x1122AB44, `resp_valid` 3 cycles after accept.
- Each of the following → `resp_err`=1 after 1 cycle with `mem_read`=`mem_write`=0 throughout:
  - load W @0x6;
  - store H @0x3;
  - funct3=011;
  - address 0x10000 with MEM_DEPTH=16384.
- Without `MAU_SUBWORD_EN`: load B @0x0 → `resp_err`=1 with no memory strobes; store W still completes in 2 cycles.
